// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain scheduler: picks one non-empty source FIFO per cycle,
// pops it through its 0-cycle read port and registers the word plus the
// source index into a valid/ready output stage. A source can keep the grant
// for up to MAX_BURST consecutive pops while others are waiting.
module fifo_rr_arbiter #(
    parameter  int NUM_SRC   = 4,
    parameter  int DWIDTH    = 32,
    parameter  int MAX_BURST = 1,
    localparam int SIDW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_SRC-1:0]        i_src_empty,
    input  logic [NUM_SRC*DWIDTH-1:0] i_src_rdata,
    output logic [NUM_SRC-1:0]        o_src_pop,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DWIDTH-1:0]         o_data,
    output logic [SIDW-1:0]           o_src_id
);

    // IDLE: output register empty; HOLD: word stalled by the consumer;
    // STREAM: a word was loaded on the last edge.
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_STREAM} state_t;

    state_t          state, state_nxt;
    logic [SIDW-1:0] holder;
    logic [SIDW-1:0] winner;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            advance;
    logic            any_src;
    logic            keep;
    logic            found;
    logic            do_pop;

    logic [DWIDTH-1:0] src_word [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_word
        assign src_word[g] = i_src_rdata[g*DWIDTH +: DWIDTH];
    end

    assign o_valid = (state != ST_IDLE);
    assign advance = ~o_valid | i_ready;
    assign any_src = ~&i_src_empty;
    assign do_pop  = advance & any_src & ~i_rst;

    // Grant selection. cnt==0 means no burst is in progress (after reset or an
    // idle cycle), so the holder does not get to keep the grant and the search
    // starts at holder+1, with the holder itself checked last.
    always_comb begin
        keep    = advance && !i_src_empty[holder] && (cnt != '0) && (cnt < CW'(MAX_BURST));
        winner  = holder;
        found   = 1'b0;
        if (!keep) begin
            for (int i = 1; i <= NUM_SRC; i++) begin
                if (!found && !i_src_empty[(int'(holder) + i) % NUM_SRC]) begin
                    winner = SIDW'((int'(holder) + i) % NUM_SRC);
                    found  = 1'b1;
                end
            end
        end
        cnt_nxt = keep ? cnt + 1'b1 : CW'(1);
    end

    // One-hot pop strobe, suppressed during reset and when the output is stalled.
    always_comb begin
        o_src_pop = '0;
        if (do_pop) o_src_pop[winner] = 1'b1;
    end

    // Next output-stage state from the handshake and source availability.
    always_comb begin
        state_nxt = state;
        if (!advance)     state_nxt = ST_HOLD;
        else if (any_src) state_nxt = ST_STREAM;
        else              state_nxt = ST_IDLE;
    end

    // State register; a word held at reset is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Output word, source id, grant holder and burst counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data   <= '0;
            o_src_id <= '0;
            holder   <= SIDW'(NUM_SRC - 1);
            cnt      <= '0;
        end else if (advance) begin
            if (any_src) begin
                o_data   <= src_word[winner];
                o_src_id <= winner;
                holder   <= winner;
                cnt      <= cnt_nxt;
            end else begin
                cnt      <= '0;
            end
        end
    end

    a_pop_onehot: assert property (@(posedge i_clk) $onehot0(o_src_pop));
    a_pop_nonempty: assert property (@(posedge i_clk) (o_src_pop & i_src_empty) == '0);
    a_stall_stable: assert property (@(posedge i_clk)
        (!i_rst && o_valid && !i_ready) |=> ($stable(o_data) && $stable(o_src_id)));

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: a per-cycle vector table on a pure
// round-robin instance, then FIFO-backed burst sequences on a MAX_BURST=4 one.
module tb_fifo_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst [2];
    logic         rdy [2];
    logic [3:0]   emp [2];
    logic [127:0] rd  [2];
    logic [3:0]   pop [2];
    logic         vld [2];
    logic [31:0]  dat [2];
    logic [1:0]   sid [2];

    logic         fifo_mode [2];
    logic [3:0]   tbl_emp   [2];
    int           cnt_f     [2][4];
    int           seq_f     [2][4];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.NUM_SRC(4), .DWIDTH(32), .MAX_BURST(1)) dut_b1 (
        .i_clk(clk), .i_rst(rst[0]), .i_src_empty(emp[0]), .i_src_rdata(rd[0]),
        .o_src_pop(pop[0]), .o_valid(vld[0]), .i_ready(rdy[0]),
        .o_data(dat[0]), .o_src_id(sid[0]));

    fifo_rr_arbiter #(.NUM_SRC(4), .DWIDTH(32), .MAX_BURST(4)) dut_b4 (
        .i_clk(clk), .i_rst(rst[1]), .i_src_empty(emp[1]), .i_src_rdata(rd[1]),
        .o_src_pop(pop[1]), .o_valid(vld[1]), .i_ready(rdy[1]),
        .o_data(dat[1]), .o_src_id(sid[1]));

    function automatic logic [31:0] tbl_word(input int k);
        case (k)
            0:       return 32'hA5A5_A5A5;
            1:       return 32'h1111_1111;
            2:       return 32'h2222_2222;
            default: return 32'h3333_3333;
        endcase
    endfunction

    // Source model: fixed table words, or FIFOs whose head word is {src, seq}.
    always_comb begin
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 4; k++) begin
                emp[u][k] = fifo_mode[u] ? (cnt_f[u][k] == 0) : tbl_emp[u][k];
                rd[u][k*32 +: 32] = fifo_mode[u] ? ((32'(k) << 28) | 32'(seq_f[u][k])) : tbl_word(k);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int u);
        @(negedge clk);
        rst[u] = 1'b1;
        rdy[u] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cnt_f[u][k] = 0;
            seq_f[u][k] = 0;
        end
        @(posedge clk);
    endtask

    // gv: one nibble per cycle, cycle 0 in the top nibble; F = no pop expected.
    task automatic run_fifo(input int u, input logic [63:0] gv, input int n, input string tag);
        int          prev;
        logic [31:0] prev_word;
        logic [3:0]  g;
        logic [3:0]  p;
        prev      = -1;
        prev_word = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst[u] = 1'b0;
            rdy[u] = 1'b1;
            #1;
            g = gv[(15-i)*4 +: 4];
            p = pop[u];
            chk($sformatf("%s_c%0d_pop", tag, i), 32'(p), (g == 4'hF) ? 32'h0 : (32'h1 << g));
            if (prev >= 0) begin
                chk($sformatf("%s_c%0d_vld", tag, i), 32'(vld[u]), 32'h1);
                chk($sformatf("%s_c%0d_id", tag, i), 32'(sid[u]), 32'(prev));
                chk($sformatf("%s_c%0d_dat", tag, i), dat[u], prev_word);
            end else begin
                chk($sformatf("%s_c%0d_vld", tag, i), 32'(vld[u]), 32'h0);
            end
            if (g != 4'hF) begin
                prev      = int'(g);
                prev_word = (32'(g) << 28) | 32'(seq_f[u][g]);
            end else begin
                prev = -1;
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (p[k] && cnt_f[u][k] > 0) begin
                    cnt_f[u][k]--;
                    seq_f[u][k]++;
                end
            end
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [3:0]  emp;
        logic [3:0]  pop;
        logic        vld;
        logic [1:0]  id;
        logic [31:0] d;
    } vec_t;

    vec_t tv [18];

    initial begin
        tv[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 32'h0000_0000};
        tv[1]  = '{1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0, 32'h0000_0000};
        tv[2]  = '{1'b0, 1'b1, 4'b0000, 4'b0010, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[3]  = '{1'b0, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd1, 32'h1111_1111};
        tv[4]  = '{1'b0, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd2, 32'h2222_2222};
        tv[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0001, 1'b1, 2'd3, 32'h3333_3333};
        tv[6]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[8]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[9]  = '{1'b0, 1'b1, 4'b0000, 4'b0010, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[10] = '{1'b0, 1'b1, 4'b1011, 4'b0100, 1'b1, 2'd1, 32'h1111_1111};
        tv[11] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b1, 2'd2, 32'h2222_2222};
        tv[12] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0, 2'd0, 32'h0000_0000};
        tv[13] = '{1'b0, 1'b0, 4'b1110, 4'b0001, 1'b0, 2'd0, 32'h0000_0000};
        tv[14] = '{1'b0, 1'b0, 4'b1110, 4'b0000, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[15] = '{1'b0, 1'b1, 4'b1110, 4'b0001, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[16] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd0, 32'hA5A5_A5A5};
        tv[17] = '{1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0, 32'h0000_0000};

        for (int u = 0; u < 2; u++) begin
            rst[u]     = 1'b1;
            rdy[u]     = 1'b1;
            tbl_emp[u] = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                cnt_f[u][k] = 0;
                seq_f[u][k] = 0;
            end
        end
        fifo_mode[0] = 1'b0;
        fifo_mode[1] = 1'b1;
        repeat (2) @(posedge clk);

        // Reset, round-robin order, backpressure, idle and reset-drop vectors.
        for (int r = 0; r < 18; r++) begin
            @(negedge clk);
            rst[0]     = tv[r].rst;
            rdy[0]     = tv[r].rdy;
            tbl_emp[0] = tv[r].emp;
            #1;
            chk($sformatf("v%0d_pop", r), 32'(pop[0]), 32'(tv[r].pop));
            chk($sformatf("v%0d_vld", r), 32'(vld[0]), 32'(tv[r].vld));
            if (tv[r].vld || tv[r].rst) begin
                chk($sformatf("v%0d_id", r), 32'(sid[0]), 32'(tv[r].id));
                chk($sformatf("v%0d_dat", r), dat[0], tv[r].d);
            end
        end

        // Pure round robin, three words in every source.
        do_reset(0);
        fifo_mode[0] = 1'b1;
        for (int k = 0; k < 4; k++) cnt_f[0][k] = 3;
        run_fifo(0, 64'h0123_0123_0123_FFFF, 14, "rr");

        // Burst of four, then the other source, then back.
        do_reset(1);
        cnt_f[1][0] = 6;
        cnt_f[1][2] = 2;
        run_fifo(1, 64'h0000_2200_FFFF_FFFF, 10, "burst");

        // Holder empties mid-burst.
        do_reset(1);
        cnt_f[1][1] = 2;
        cnt_f[1][3] = 3;
        run_fifo(1, 64'h1133_3FFF_FFFF_FFFF, 7, "short");

        // Single source streams back to back across burst boundaries.
        do_reset(1);
        cnt_f[1][2] = 10;
        run_fifo(1, 64'h2222_2222_22FF_FFFF, 12, "solo");

        // Reset in the middle of a stream drops the in-flight word.
        do_reset(1);
        cnt_f[1][2] = 5;
        run_fifo(1, 64'h22FF_FFFF_FFFF_FFFF, 2, "pre");
        @(negedge clk);
        rst[1] = 1'b1;
        #1;
        chk("midrst_pop", 32'(pop[1]), 32'h0);
        chk("midrst_vld", 32'(vld[1]), 32'h1);
        chk("midrst_id", 32'(sid[1]), 32'h2);
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        chk("postrst_vld", 32'(vld[1]), 32'h0);
        chk("postrst_dat", dat[1], 32'h0);
        chk("postrst_pop", 32'(pop[1]), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
